// File: rtl/slow2fast_buffer.sv
// Slow-to-fast AXI-Stream crossing buffer, clocked entirely by the fast clock.
// Beats are sampled once per slow period into a small FIFO and replayed at fast rate.
module slow2fast_buffer #(
    parameter int DWIDTH = 128,
    parameter int RATIO  = 2,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(RATIO)-1:0] clk_cnt,
    input  logic [DWIDTH-1:0]        s_axis_tdata,
    input  logic [DWIDTH/8-1:0]      s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [DWIDTH-1:0]        m_axis_tdata,
    output logic [DWIDTH/8-1:0]      m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
);

    localparam int CW = $clog2(RATIO);
    localparam int KW = DWIDTH / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DWIDTH-1:0] data_mem [DEPTH];
    logic [KW-1:0]     keep_mem [DEPTH];
    logic              last_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_next;
    logic          ready_q;
    logic          sample;
    logic          wr;
    logic          rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The fast edge that closes the last phase of a slow period is the only
    // point where the slow-domain inputs are guaranteed stable.
    assign sample   = (clk_cnt == CW'(RATIO - 1));
    assign wr       = sample && s_axis_tvalid && ready_q;
    assign rd       = (occ != '0) && m_axis_tready;
    assign occ_next = occ + OW'(wr) - OW'(rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            ready_q <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ <= occ_next;
            // Ready is only re-evaluated once per slow period; occupancy can
            // only fall between sample edges, so an advertised slot stays free.
            if (sample) begin
                ready_q <= (occ_next < OW'(DEPTH));
            end
        end
    end

    // NOTE: the entries themselves are reset, not just the pointers, so the
    // head outputs read as zero while rst is held and no stale beat survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                keep_mem[i] <= '0;
                last_mem[i] <= 1'b0;
            end
        end else if (wr) begin
            data_mem[wr_ptr] <= s_axis_tdata;
            keep_mem[wr_ptr] <= s_axis_tkeep;
            last_mem[wr_ptr] <= s_axis_tlast;
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = (occ != '0);
    assign m_axis_tdata  = data_mem[rd_ptr];
    assign m_axis_tkeep  = keep_mem[rd_ptr];
    assign m_axis_tlast  = last_mem[rd_ptr];

endmodule

// File: tb/tb_slow2fast_buffer.sv
// Bench for slow2fast_buffer: directed RATIO=2/DEPTH=2 scenarios plus a
// randomised RATIO=4/DEPTH=3 run, all checked against a queue of accepted beats.
module tb_slow2fast_buffer;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    logic clk;
    logic rst;

    // Instance A: RATIO=2, DEPTH=2, DWIDTH=128
    logic [0:0]   a_cnt;
    logic [127:0] a_sdata;
    logic [15:0]  a_skeep;
    logic         a_slast;
    logic         a_svalid;
    logic         a_sready;
    logic [127:0] a_mdata;
    logic [15:0]  a_mkeep;
    logic         a_mlast;
    logic         a_mvalid;
    logic         a_mready;

    // Instance B: RATIO=4, DEPTH=3, DWIDTH=32
    logic [1:0]   b_cnt;
    logic [31:0]  b_sdata;
    logic [3:0]   b_skeep;
    logic         b_slast;
    logic         b_svalid;
    logic         b_sready;
    logic [31:0]  b_mdata;
    logic [3:0]   b_mkeep;
    logic         b_mlast;
    logic         b_mvalid;
    logic         b_mready;

    int    vectors = 0;
    int    errors  = 0;
    int    b_pushed = 0;
    int    b_popped = 0;
    bit    b_done = 0;
    beat_t exp_a[$];
    beat_t exp_b[$];
    beat_t ea;
    beat_t eb;

    slow2fast_buffer #(.DWIDTH(128), .RATIO(2), .DEPTH(2)) u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .clk_cnt       (a_cnt),
        .s_axis_tdata  (a_sdata),
        .s_axis_tkeep  (a_skeep),
        .s_axis_tlast  (a_slast),
        .s_axis_tvalid (a_svalid),
        .s_axis_tready (a_sready),
        .m_axis_tdata  (a_mdata),
        .m_axis_tkeep  (a_mkeep),
        .m_axis_tlast  (a_mlast),
        .m_axis_tvalid (a_mvalid),
        .m_axis_tready (a_mready)
    );

    slow2fast_buffer #(.DWIDTH(32), .RATIO(4), .DEPTH(3)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .clk_cnt       (b_cnt),
        .s_axis_tdata  (b_sdata),
        .s_axis_tkeep  (b_skeep),
        .s_axis_tlast  (b_slast),
        .s_axis_tvalid (b_svalid),
        .s_axis_tready (b_sready),
        .m_axis_tdata  (b_mdata),
        .m_axis_tkeep  (b_mkeep),
        .m_axis_tlast  (b_mlast),
        .m_axis_tvalid (b_mvalid),
        .m_axis_tready (b_mready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slow-phase counters: wrap to 0 on the edge that closes the slow period.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            a_cnt <= a_cnt + 1'b1;
            b_cnt <= b_cnt + 2'd1;
        end
    end

    // Scoreboard A: a read happens at the next rising edge when valid&ready here.
    always @(negedge clk) begin
        #1;
        if (!rst && a_mvalid && a_mready) begin
            vectors++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_beat: got data=%h keep=%h last=%b, required no beat",
                         a_mdata, a_mkeep, a_mlast);
            end else begin
                ea = exp_a.pop_front();
                if (a_mdata !== ea.data || a_mkeep !== ea.keep || a_mlast !== ea.last) begin
                    errors++;
                    $display("FAIL a_beat: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                             a_mdata, a_mkeep, a_mlast, ea.data, ea.keep, ea.last);
                end
            end
        end
    end

    // Scoreboard B
    always @(negedge clk) begin
        #1;
        if (!rst && b_mvalid && b_mready) begin
            vectors++;
            b_popped++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_beat: got data=%h, required no beat", b_mdata);
            end else begin
                eb = exp_b.pop_front();
                if (b_mdata !== eb.data[31:0] || b_mkeep !== eb.keep[3:0] || b_mlast !== eb.last) begin
                    errors++;
                    $display("FAIL b_beat: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                             b_mdata, b_mkeep, b_mlast, eb.data[31:0], eb.keep[3:0], eb.last);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    task automatic sync_a(input logic [0:0] ph);
        int n = 0;
        while (a_cnt !== ph && n < 8) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 8) begin
            errors++;
            $display("FAIL sync_a: got phase %0d, required %0d", a_cnt, ph);
        end
    endtask

    // Offer a beat on A from a negedge; returns at the negedge after acceptance.
    task automatic send_a(input logic [127:0] d, input logic [15:0] k, input logic l);
        int n = 0;
        a_sdata  = d;
        a_skeep  = k;
        a_slast  = l;
        a_svalid = 1'b1;
        while (!(a_cnt == 1'b1 && a_sready === 1'b1) && n < 64) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 64) begin
            errors++;
            $display("FAIL send_a_timeout: beat %h not accepted, required acceptance", d);
        end else begin
            exp_a.push_back('{data: d, keep: k, last: l});
        end
        @(negedge clk);
        a_svalid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        b_sdata  = d;
        b_skeep  = k;
        b_slast  = l;
        b_svalid = 1'b1;
        while (!(b_cnt == 2'd3 && b_sready === 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 400) begin
            errors++;
            $display("FAIL send_b_timeout: beat %h not accepted, required acceptance", d);
        end else begin
            exp_b.push_back('{data: {96'b0, d}, keep: {12'b0, k}, last: l});
            b_pushed++;
        end
        @(negedge clk);
        b_svalid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (a_mvalid !== 1'b0 || a_sready !== 1'b0 || a_mdata !== '0 || a_mkeep !== '0 || a_mlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_a: got valid=%b ready=%b data=%h, required 0 0 0", a_mvalid, a_sready, a_mdata);
        end
        vectors++;
        if (b_mvalid !== 1'b0 || b_sready !== 1'b0 || b_mdata !== '0) begin
            errors++;
            $display("FAIL reset_state_b: got valid=%b ready=%b data=%h, required 0 0 0", b_mvalid, b_sready, b_mdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sync_a(1'b1);
        vectors++;
        if (a_sready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_sample: got %b, required 0", a_sready);
        end
        @(negedge clk);
        vectors++;
        if (a_sready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_sample: got %b, required 1", a_sready);
        end
        // Store two beats, then reset asynchronously mid-cycle.
        a_mready = 1'b0;
        send_a(128'h1111, 16'hFFFF, 1'b0);
        send_a(128'h2222, 16'hFFFF, 1'b1);
        vectors++;
        if (a_mvalid !== 1'b1 || a_sready !== 1'b0) begin
            errors++;
            $display("FAIL two_stored: got valid=%b ready=%b, required 1 0", a_mvalid, a_sready);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (a_mvalid !== 1'b0 || a_sready !== 1'b0 || a_mdata !== '0 || a_mkeep !== '0 || a_mlast !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b ready=%b data=%h, required 0 0 0", a_mvalid, a_sready, a_mdata);
        end
        exp_a.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        a_mready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (a_mvalid !== 1'b0) begin
                errors++;
                $display("FAIL stale_beat: got valid=%b data=%h, required valid 0", a_mvalid, a_mdata);
            end
        end
        vectors++;
        if (a_sready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b, required 1", a_sready);
        end
    endtask

    task automatic test_streaming;
        logic [127:0] d;
        sync_a(1'b1);
        a_mready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 128'hA + 128'(i);
            a_sdata  = d;
            a_skeep  = (i == 3) ? 16'h0FFF : 16'hFFFF;
            a_slast  = (i == 3);
            a_svalid = 1'b1;
            vectors++;
            if (a_sready !== 1'b1 || a_mvalid !== 1'b0) begin
                errors++;
                $display("FAIL stream_phase1_%0d: got ready=%b valid=%b, required 1 0", i, a_sready, a_mvalid);
            end
            exp_a.push_back('{data: d, keep: a_skeep, last: a_slast});
            @(negedge clk);
            a_svalid = 1'b0;
            vectors++;
            if (a_mvalid !== 1'b1) begin
                errors++;
                $display("FAIL stream_phase0_%0d: got valid=%b, required 1", i, a_mvalid);
            end
            @(negedge clk);
        end
        vectors++;
        if (a_mvalid !== 1'b0 || exp_a.size() != 0) begin
            errors++;
            $display("FAIL stream_end: got valid=%b pending=%0d, required 0 0", a_mvalid, exp_a.size());
        end
    endtask

    task automatic test_backpressure;
        sync_a(1'b1);
        a_mready = 1'b0;
        send_a(128'hA, 16'hFFFF, 1'b0);
        vectors++;
        if (a_sready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_one: got %b, required 1", a_sready);
        end
        send_a(128'hB, 16'h00FF, 1'b0);
        vectors++;
        if (a_sready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_full: got %b, required 0", a_sready);
        end
        a_sdata  = 128'hC;
        a_skeep  = 16'hF0F0;
        a_slast  = 1'b1;
        a_svalid = 1'b1;
        @(negedge clk);
        vectors++;
        if (a_sready !== 1'b0 || a_mvalid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got ready=%b valid=%b, required 0 1", a_sready, a_mvalid);
        end
        @(negedge clk);
        a_mready = 1'b1;
        @(negedge clk);
        vectors++;
        if (a_sready !== 1'b0 || a_mvalid !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_held: got ready=%b valid=%b, required 0 1", a_sready, a_mvalid);
        end
        @(negedge clk);
        vectors++;
        if (a_sready !== 1'b1 || a_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_return: got ready=%b valid=%b, required 1 0", a_sready, a_mvalid);
        end
        send_a(128'hC, 16'hF0F0, 1'b1);
        vectors++;
        if (a_mvalid !== 1'b1) begin
            errors++;
            $display("FAIL bp_c_visible: got valid=%b, required 1", a_mvalid);
        end
        @(negedge clk);
        vectors++;
        if (exp_a.size() != 0) begin
            errors++;
            $display("FAIL bp_drained: got pending=%0d, required 0", exp_a.size());
        end
    endtask

    task automatic test_sampling_phase;
        sync_a(1'b1);
        a_mready = 1'b1;
        @(negedge clk);
        a_sdata  = 128'hDEAD;
        a_svalid = 1'b1;
        @(negedge clk);
        a_svalid = 1'b0;
        a_sdata  = 128'hBEEF;
        @(negedge clk);
        vectors++;
        if (a_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL phase_no_write: got valid=%b, required 0", a_mvalid);
        end
        a_sdata  = 128'hBAD0;
        a_slast  = 1'b1;
        a_svalid = 1'b1;
        @(negedge clk);
        a_sdata  = 128'h5A5A;
        a_skeep  = 16'h1234;
        a_slast  = 1'b0;
        vectors++;
        if (a_sready !== 1'b1) begin
            errors++;
            $display("FAIL phase_ready: got %b, required 1", a_sready);
        end
        exp_a.push_back('{data: 128'h5A5A, keep: 16'h1234, last: 1'b0});
        @(negedge clk);
        a_sdata  = 128'hFFFF;
        a_svalid = 1'b0;
        vectors++;
        if (a_mvalid !== 1'b1) begin
            errors++;
            $display("FAIL phase_captured: got valid=%b, required 1", a_mvalid);
        end
        @(negedge clk);
        vectors++;
        if (exp_a.size() != 0 || a_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL phase_end: got pending=%0d valid=%b, required 0 0", exp_a.size(), a_mvalid);
        end
    endtask

    task automatic test_simultaneous;
        sync_a(1'b1);
        // One entry held, then pop and push at the same sample edge.
        a_mready = 1'b0;
        send_a(128'h100, 16'hFFFF, 1'b0);
        @(negedge clk);
        a_mready = 1'b1;
        a_sdata  = 128'h200;
        a_skeep  = 16'h00F0;
        a_slast  = 1'b1;
        a_svalid = 1'b1;
        vectors++;
        if (a_sready !== 1'b1 || a_mvalid !== 1'b1) begin
            errors++;
            $display("FAIL rw_pre: got ready=%b valid=%b, required 1 1", a_sready, a_mvalid);
        end
        exp_a.push_back('{data: 128'h200, keep: 16'h00F0, last: 1'b1});
        @(negedge clk);
        a_svalid = 1'b0;
        vectors++;
        if (a_mvalid !== 1'b1 || a_sready !== 1'b1) begin
            errors++;
            $display("FAIL rw_same_edge: got valid=%b ready=%b, required 1 1", a_mvalid, a_sready);
        end
        @(negedge clk);
        vectors++;
        if (a_mvalid !== 1'b0 || exp_a.size() != 0) begin
            errors++;
            $display("FAIL rw_end: got valid=%b pending=%0d, required 0 0", a_mvalid, exp_a.size());
        end
        // Full FIFO: a pop at the sample edge re-opens ready at that same edge.
        a_mready = 1'b0;
        send_a(128'h300, 16'hFFFF, 1'b0);
        send_a(128'h400, 16'hFFFF, 1'b0);
        @(negedge clk);
        a_mready = 1'b1;
        a_sdata  = 128'h500;
        a_skeep  = 16'hFFFF;
        a_slast  = 1'b1;
        a_svalid = 1'b1;
        vectors++;
        if (a_sready !== 1'b0 || a_mvalid !== 1'b1) begin
            errors++;
            $display("FAIL full_pre: got ready=%b valid=%b, required 0 1", a_sready, a_mvalid);
        end
        @(negedge clk);
        vectors++;
        if (a_sready !== 1'b1 || a_mvalid !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_at_sample: got ready=%b valid=%b, required 1 1", a_sready, a_mvalid);
        end
        send_a(128'h500, 16'hFFFF, 1'b1);
        @(negedge clk);
        vectors++;
        if (exp_a.size() != 0 || a_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL full_end: got pending=%0d valid=%b, required 0 0", exp_a.size(), a_mvalid);
        end
    endtask

    task automatic test_random_ratio4;
        int n;
        b_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    send_b($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                end
                b_done = 1'b1;
            end
            begin
                while (!b_done) begin
                    @(negedge clk);
                    b_mready = ($urandom_range(0, 3) != 0);
                end
            end
            begin : ready_watch
                logic prev;
                prev = b_sready;
                while (!b_done) begin
                    @(negedge clk);
                    vectors++;
                    if (b_sready !== prev && b_cnt != 2'd0) begin
                        errors++;
                        $display("FAIL b_ready_phase: ready changed to %b in phase %0d, required change only after phase 3",
                                 b_sready, b_cnt);
                    end
                    prev = b_sready;
                    #2;
                    vectors++;
                    if (exp_b.size() > 3) begin
                        errors++;
                        $display("FAIL b_occupancy: got %0d, required <= 3", exp_b.size());
                    end
                end
            end
        join
        b_mready = 1'b1;
        n = 0;
        while (exp_b.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        vectors++;
        if (exp_b.size() != 0 || b_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL b_drain: got pending=%0d valid=%b, required 0 0", exp_b.size(), b_mvalid);
        end
        vectors++;
        if (b_pushed != 1000 || b_popped != 1000) begin
            errors++;
            $display("FAIL b_count: got pushed=%0d popped=%0d, required 1000 1000", b_pushed, b_popped);
        end
    endtask

    initial begin
        rst      = 1'b1;
        a_sdata  = '0;
        a_skeep  = '0;
        a_slast  = 1'b0;
        a_svalid = 1'b0;
        a_mready = 1'b0;
        b_sdata  = '0;
        b_skeep  = '0;
        b_slast  = 1'b0;
        b_svalid = 1'b0;
        b_mready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_sampling_phase();
        test_simultaneous();
        test_random_ratio4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
